// File: rtl/spi_accel_responder.sv
// rtl/spi_accel_responder.sv - SPI mode-0 slave emulating the 3-axis accelerometer register map
//
// Oversamples sclk/cs/mosi on clk, decodes write (0x0A) / read (0x0B) commands
// with address auto-increment, and serves a 2**ADDR_W x 8 register file.
// Addresses 0x00-0x0F are read-only (ID, axis data, status); 0x10 and up are writable.
// Optional feature macro: RESP_DRDY_EN (STATUS 0x0B bit0 DATA_READY + drdy port).
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, cs, mosi        SPI bus from the master (cs active low, sclk idles low)
//   miso, miso_oe         slave data and its output enable (high while cs low)
//   sample_valid          one-clk strobe qualifying x_data/y_data/z_data
//   x_data,y_data,z_data  signed axis samples
//   wr_strobe             one-clk pulse per committed register write
//   wr_addr, wr_data      address/data of that write
//   measure_en            reg 0x2D[1:0] == 2'b10
//   drdy                  (RESP_DRDY_EN only) mirror of STATUS.DATA_READY
module spi_accel_responder #(
  parameter int         ADDR_W      = 6,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              sample_valid,
  input  logic [7:0]        x_data,
  input  logic [7:0]        y_data,
  input  logic [7:0]        z_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
`ifdef RESP_DRDY_EN
  output logic              drdy,
`endif
  output logic              measure_en
);

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic s_sclk, s_cs, s_mosi, sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [6:0]        tx_shift;
  logic [7:0]        rx_byte, rd_byte;
  logic [ADDR_W-1:0] addr_ptr;
  logic              is_read, load_pend, rd_load, wr_commit;
  logic              sample_now, pend_apply, pend_valid;
  logic [7:0]        ax_x, ax_y, ax_z, pend_x, pend_y, pend_z;
  logic [7:0]        regs [16:(1<<ADDR_W)-1];
`ifdef RESP_DRDY_EN
  logic              drdy_bit;
`endif

  // Synchronizers plus one extra flop each for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= s_sclk;
      cs_d      <= s_cs;
    end
  end

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_cs      = cs_sync[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_d;
  assign sclk_fall = ~s_sclk & sclk_d;
  assign cs_rise   = s_cs & ~cs_d;
  assign cs_fall   = ~s_cs & cs_d;
  assign rx_byte   = {rx_shift, s_mosi};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nx = CMD;
        CMD:     if (byte_done)
                   state_nx = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_nx = is_read ? RDATA : WDATA;
        default: state_nx = state;
      endcase
    end
  end

  // cs edges take priority so a byte cut short by cs rise never commits.
  assign wr_commit = byte_done && state == WDATA && !cs_rise && !cs_fall &&
                     addr_ptr >= ADDR_W'(16);
  assign rd_load   = sclk_fall && state == RDATA && load_pend && !cs_rise && !cs_fall;

  always_comb begin
    rd_byte = 8'h00;
    if (addr_ptr >= ADDR_W'(16)) begin
      rd_byte = regs[addr_ptr];
    end else begin
      case (addr_ptr[3:0])
        4'h0:    rd_byte = DEVID;
        4'h1:    rd_byte = 8'h1D;
        4'h2:    rd_byte = 8'hF2;
        4'h8:    rd_byte = ax_x;
        4'h9:    rd_byte = ax_y;
        4'hA:    rd_byte = ax_z;
`ifdef RESP_DRDY_EN
        4'hB:    rd_byte = {7'b0, drdy_bit};
`endif
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      addr_ptr  <= '0;
      is_read   <= 1'b0;
      load_pend <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      miso_oe   <= ~s_cs;
      if (cs_rise || cs_fall) begin
        bit_cnt   <= '0;
        miso      <= 1'b0;
        load_pend <= 1'b0;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        if (byte_done) begin
          case (state)
            CMD:  is_read <= (rx_byte == CMD_READ);
            ADDR: begin
              addr_ptr  <= rx_byte[ADDR_W-1:0];
              load_pend <= 1'b1;
            end
            WDATA: begin
              if (wr_commit) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_ptr;
                wr_data   <= rx_byte;
              end
              addr_ptr <= addr_ptr + ADDR_W'(1);
            end
            RDATA: begin
              addr_ptr  <= addr_ptr + ADDR_W'(1);
              load_pend <= 1'b1;
            end
            default: ;
          endcase
        end
        // First fall after a byte boundary presents the MSB; the next 7 shift.
        if (rd_load) begin
          miso      <= rd_byte[7];
          tx_shift  <= rd_byte[6:0];
          load_pend <= 1'b0;
        end else if (sclk_fall && state == RDATA) begin
          miso     <= tx_shift[6];
          tx_shift <= {tx_shift[5:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 16; i < (1 << ADDR_W); i++) regs[ADDR_W'(i)] <= 8'h00;
    end else if (wr_commit) begin
      regs[addr_ptr] <= rx_byte;
    end
  end

  assign measure_en = (regs[ADDR_W'(45)][1:0] == 2'b10);

  // Samples arriving during a transaction are parked so a burst read stays coherent.
  assign sample_now = sample_valid && (state == IDLE || cs_rise);
  assign pend_apply = !sample_valid && pend_valid && state == IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_x       <= '0;
      ax_y       <= '0;
      ax_z       <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      pend_valid <= 1'b0;
    end else if (sample_now) begin
      ax_x       <= x_data;
      ax_y       <= y_data;
      ax_z       <= z_data;
      pend_valid <= 1'b0;
    end else if (sample_valid) begin
      pend_x     <= x_data;
      pend_y     <= y_data;
      pend_z     <= z_data;
      pend_valid <= 1'b1;
    end else if (pend_apply) begin
      ax_x       <= pend_x;
      ax_y       <= pend_y;
      ax_z       <= pend_z;
      pend_valid <= 1'b0;
    end
  end

`ifdef RESP_DRDY_EN
  // Set has priority over the read-side clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   drdy_bit <= 1'b0;
    else if (sample_now || pend_apply)            drdy_bit <= 1'b1;
    else if (rd_load && addr_ptr == ADDR_W'(8))   drdy_bit <= 1'b0;
  end

  assign drdy = drdy_bit;
`endif

endmodule

// File: tb/tb_spi_accel_responder.sv
// tb/tb_spi_accel_responder.sv - directed self-checking bench for spi_accel_responder
module tb_spi_accel_responder;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs, mosi, miso, miso_oe, sample_valid;
  logic [7:0] x_data, y_data, z_data, wr_data;
  logic [5:0] wr_addr;
  logic       wr_strobe, measure_en;
`ifdef RESP_DRDY_EN
  logic       drdy;
`endif

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;
  int miso_hi = 0;
  int base_stb, base_hi;
  logic [5:0] stb_addr = '0;
  logic [7:0] stb_data = '0;
  logic [7:0] tx [8];
  logic [7:0] rx [8];
  int   inj = -1;
  logic oe_mid = 1'b0;

  spi_accel_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .sample_valid (sample_valid),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef RESP_DRDY_EN
    .drdy         (drdy),
`endif
    .measure_en   (measure_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) begin
      stb_cnt++;
      stb_addr = wr_addr;
      stb_data = wr_data;
    end
    if (miso) miso_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      tick(7);
      r[i] = miso;
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input int n, input int last_bits);
    logic [7:0] r;
    base_stb = stb_cnt;
    base_hi  = miso_hi;
    cs = 1'b0;
    tick(8);
    for (int k = 0; k < n; k++) begin
      if (k == inj) begin
        x_data = 8'h55; y_data = 8'h55; z_data = 8'h55;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
      end
      spi_bits(tx[k], (k == n - 1) ? last_bits : 8, r);
      rx[k] = r;
      if (k == 1) oe_mid = miso_oe;
    end
    tick(8);
    cs = 1'b1;
    tick(12);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; sample_valid = 1'b0;
    x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
    tick(5);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_measure_en", measure_en, 0);
    rst_n = 1'b1;
    tick(5);

    tx = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 8);
    check("id_cmd_byte", rx[0], 8'h00);
    check("id_devid", rx[2], 8'hAD);
    check("id_reg01", rx[3], 8'h1D);
    check("oe_during_cs", oe_mid, 1);
    check("oe_after_cs", miso_oe, 0);

    tx = '{8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("w2d_strobes", stb_cnt - base_stb, 1);
    check("w2d_addr", stb_addr, 6'h2D);
    check("w2d_data", stb_data, 8'h02);
    check("measure_en_on", measure_en, 1);
    tx = '{8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("r2d", rx[2], 8'h02);

    x_data = 8'h12; y_data = 8'hF0; z_data = 8'h7F;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    tick(2);
    inj = 3;
    tx = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(5, 8);
    inj = -1;
    check("axis_x", rx[2], 8'h12);
    check("axis_y", rx[3], 8'hF0);
    check("axis_z", rx[4], 8'h7F);
    xfer(5, 8);
    check("pend_x", rx[2], 8'h55);
    check("pend_y", rx[3], 8'h55);
    check("pend_z", rx[4], 8'h55);

    tx = '{8'h0D, 8'h2D, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("ign_strobes", stb_cnt - base_stb, 0);
    check("ign_miso_high_clks", miso_hi - base_hi, 0);
    check("ign_measure_en", measure_en, 1);
    tx = '{8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("ign_r2d", rx[2], 8'h02);

    tx = '{8'h0A, 8'h3F, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 8);
    check("wrap_strobes", stb_cnt - base_stb, 1);
    check("wrap_addr", stb_addr, 6'h3F);
    check("wrap_data", stb_data, 8'hAA);
    tx = '{8'h0B, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 8);
    check("wrap_r3f", rx[2], 8'hAA);
    check("wrap_r00_devid", rx[3], 8'hAD);

    tx = '{8'h0A, 8'h0F, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 8);
    check("ro_edge_strobes", stb_cnt - base_stb, 1);
    check("ro_edge_addr", stb_addr, 6'h10);
    check("ro_edge_data", stb_data, 8'h22);
    tx = '{8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 8);
    check("ro_edge_r0f", rx[2], 8'h00);
    check("ro_edge_r10", rx[3], 8'h22);

    tx = '{8'h0A, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 5);
    check("partial_strobes", stb_cnt - base_stb, 0);
    tx = '{8'h0B, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("partial_r20", rx[2], 8'h00);
    tx = '{8'h0A, 8'h21, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(3, 8);
    check("after_partial_strobes", stb_cnt - base_stb, 1);
    check("after_partial_addr", stb_addr, 6'h21);
    check("after_partial_data", stb_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
- SPI mode-0 slave that emulates the 3-axis accelerometer register interface driven by our SPI master. It is the bus-side counterpart used for loop-back bring-up on the FPGA and as the device model in the master's bench.
- Oversamples sclk/cs/mosi on the system clock, decodes write (0x0A) and read (0x0B) register commands with address auto-increment, and serves a 64x8 register file with read-only ID and axis-data registers.

Parameters:
- ADDR_W, 6, register address width; the file holds 2**ADDR_W bytes.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs/mosi (minimum 2).
- DEVID, 8'hAD, value returned at address 0x00.

Ports:
- clk  in  1  system clock (100 MHz); must be at least 8x the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from the master (idles low).
- cs  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  high while cs is synchronized low.
- sample_valid  in  1  one-clk strobe: the x/y/z inputs are new.
- x_data, y_data, z_data  in  8 each  signed axis samples.
- wr_strobe  out  1  one-clk pulse per committed register write.
- wr_addr  out  ADDR_W  address of the committed write.
- wr_data  out  8  data of the committed write.
- measure_en  out  1  high when reg 0x2D[1:0] == 2'b10.

Behaviour:
- Reset (rst_n low, asynchronous): miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, FSM=IDLE, bit_cnt=0.
  - Registers take these values: 0x00=DEVID, 0x01=8'h1D, 0x02=8'hF2, 0x2D=0. All others are 0.
- Synchronized inputs feed an edge detector. A sclk rise samples mosi, MSB first. A sclk fall shifts miso.
- Latency: miso updates SYNC_STAGES+1 clks after the sclk fall.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - cs fall -> CMD, bit_cnt=0.
  - After the 8th rise in CMD: 0x0A -> ADDR (write), 0x0B -> ADDR (read), any other value -> IGNORE.
  - After the 8th rise in ADDR: addr_ptr = byte[ADDR_W-1:0]; go to WDATA or RDATA.
  - WDATA: after each 8th rise, commit the byte.
    - If addr_ptr >= 0x10: write the register, pulse wr_strobe the next clk with wr_addr/wr_data.
    - Addresses 0x00-0x0F are read-only: the write is dropped with no strobe.
    - Then addr_ptr increments.
  - RDATA: on the first sclk fall after each byte boundary, load tx_shift = reg[addr_ptr] and drive its MSB. The following 7 falls shift. addr_ptr increments at the 8th rise.
  - IGNORE: miso held 0 until cs rises.
- addr_ptr wraps from 2**ADDR_W-1 to 0.
- Any state: cs rise -> IDLE, miso=0, miso_oe=0. A partially received byte (fewer than 8 rises) is discarded; no write, no strobe.
- Axis registers: 0x08=x_data, 0x09=y_data, 0x0A=z_data.
  - sample_valid while IDLE: update all three in the same clk.
  - sample_valid while cs is low: latch into a pending buffer (newest wins). Apply on the clk after cs rises, so a burst read is always coherent.
- Simultaneous cs rise and sample_valid: the new sample is applied; the pending buffer is cleared.
- measure_en is combinational from reg 0x2D.

Optional Feature:
- Macro RESP_DRDY_EN.
- Defined:
  - Register 0x0B (STATUS) bit0 = DATA_READY. It is set when an axis update is applied.
  - It is cleared when a read transaction's RDATA phase outputs address 0x08.
  - Extra output port drdy (1 bit) mirrors the bit.
  - If set and clear happen in the same clk, set wins.
- Undefined: 0x0B reads 0, no drdy port.

Test Plan:
- rst_n low then high. Transaction 0x0B,0x00,0x00,0x00 -> miso bytes 3,4 = 0xAD,0x1D; miso_oe high only while cs is low.
- Transaction 0x0A,0x2D,0x02 -> single wr_strobe with wr_addr=0x2D, wr_data=0x02; measure_en=1. A read of 0x2D returns 0x02.
- Idle sample_valid with x=0x12, y=0xF0, z=0x7F, then read 0x0B,0x08 plus 3 dummy bytes -> 0x12,0xF0,0x7F. A sample_valid (0x55 on each axis) mid-burst does not change the bytes; the next read returns 0x55.
- Command 0x0D,0x2D,0xFF -> no wr_strobe; miso=0 throughout; reg 0x2D unchanged.
- Write 0x0A,0x3F,0xAA,0xBB -> writes to 0x3F then 0x00. 0x00 is read-only: only one strobe, DEVID still 0xAD.
- Write 0x0A,0x20 then cs rises after 5 data bits -> no strobe, reg 0x20 unchanged. The next transaction decodes normally.
